// File: rtl/rr_mux_arb.sv
`default_nettype none
// ============================================================================
// Module   : rr_mux_arb
// Brief    : N-channel round-robin arbiter/mux with a single registered output
//            slot. Optional macro RR_MUX_FORCE_SEL_EN adds a forced-select path.
// Revision : 1.0 - initial release
// ============================================================================
module rr_mux_arb #(
    parameter  int WIDTH = 8,
    parameter  int N     = 4,
    localparam int SW    = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]     in_valid,
    output logic [N-1:0]     in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [SW-1:0]    out_sel,
    output logic             out_valid,
`ifdef RR_MUX_FORCE_SEL_EN
    input  logic             force_en,
    input  logic [SW-1:0]    force_sel,
`endif
    input  logic             out_ready
);

    localparam logic [N-1:0] c_one_hot0 = {{(N-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_out_data;
    logic [SW-1:0]    r_out_sel;
    logic             r_out_valid;
    logic [SW-1:0]    r_ptr;

    logic             w_load_en;
    logic             w_found;
    logic             w_forced;
    logic             w_xfer;
    logic [SW-1:0]    w_grant_idx;
    logic [SW-1:0]    w_ptr_next;
    int               w_idx;

    assign w_load_en = !r_out_valid || out_ready;

    // Scan from ptr upward with wrap; the first requesting channel wins.
    always_comb begin
        w_found     = 1'b0;
        w_forced    = 1'b0;
        w_grant_idx = '0;
        w_idx       = 0;
        for (int k = 0; k < N; k++) begin
            w_idx = (int'(r_ptr) + k) % N;
            if (!w_found && in_valid[w_idx]) begin
                w_found     = 1'b1;
                w_grant_idx = w_idx[SW-1:0];
            end
        end
`ifdef RR_MUX_FORCE_SEL_EN
        if (force_en) begin
            w_forced    = 1'b1;
            w_grant_idx = force_sel;
            w_found     = (int'(force_sel) < N) ? in_valid[force_sel] : 1'b0;
        end
`endif
    end

    assign w_xfer     = w_load_en && w_found && !rst;
    assign w_ptr_next = (int'(w_grant_idx) == N - 1) ? '0 : w_grant_idx + 1'b1;
    assign in_ready   = w_xfer ? (c_one_hot0 << w_grant_idx) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_data  <= '0;
            r_out_sel   <= '0;
            r_out_valid <= 1'b0;
            r_ptr       <= '0;
        end else if (w_load_en) begin
            if (w_found) begin
                r_out_data  <= in_data[w_grant_idx*WIDTH +: WIDTH];
                r_out_sel   <= w_grant_idx;
                r_out_valid <= 1'b1;
                if (!w_forced) begin
                    r_ptr <= w_ptr_next;
                end
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_sel   = r_out_sel;
    assign out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_rr_mux_arb.sv
`default_nettype none
// Directed self-checking bench for rr_mux_arb (N=4, WIDTH=8).
module tb_rr_mux_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [7:0]  out_data;
    logic [1:0]  out_sel;
    logic        out_valid;
    logic        out_ready;
`ifdef RR_MUX_FORCE_SEL_EN
    logic        force_en;
    logic [1:0]  force_sel;
`endif

    int vectors = 0;
    int errors  = 0;

    rr_mux_arb #(.WIDTH(8), .N(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_valid (out_valid),
`ifdef RR_MUX_FORCE_SEL_EN
        .force_en  (force_en),
        .force_sel (force_sel),
`endif
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [7:0] d, input logic [1:0] s);
        check({tag, ".valid"}, 64'(out_valid), 64'(v));
        check({tag, ".data"},  64'(out_data),  64'(d));
        check({tag, ".sel"},   64'(out_sel),   64'(s));
    endtask

    task automatic chk_rdy(input string tag, input logic [3:0] r);
        #1;
        check({tag, ".in_ready"}, 64'(in_ready), 64'(r));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] exp_d;
        in_data   = {8'h08, 8'h04, 8'h02, 8'h01};
        rst       = 1'b1;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
`ifdef RR_MUX_FORCE_SEL_EN
        force_en  = 1'b0;
        force_sel = 2'd0;
`endif
        tick;
        chk_rdy("reset", 4'b0000);
        tick;
        chk_out("reset", 1'b0, 8'h00, 2'd0);

        // Full rotation twice with all channels requesting.
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            exp_d = 8'h01 << (k % 4);
            chk_rdy("rr", 4'b0001 << (k % 4));
            tick;
            chk_out("rr", 1'b1, exp_d, 2'(k % 4));
        end

        // Single requester keeps winning.
        in_valid = 4'b0100;
        for (int k = 0; k < 3; k++) begin
            chk_rdy("solo", 4'b0100);
            tick;
            chk_out("solo", 1'b1, 8'h04, 2'd2);
        end

        // Load ch1 then stall the output for three cycles.
        in_valid = 4'b0010;
        tick;
        chk_out("load1", 1'b1, 8'h02, 2'd1);
        in_valid  = 4'b1111;
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk_rdy("stall", 4'b0000);
            tick;
            chk_out("stall", 1'b1, 8'h02, 2'd1);
        end
        out_ready = 1'b1;
        chk_rdy("unstall", 4'b0100);
        tick;
        chk_out("unstall", 1'b1, 8'h04, 2'd2);

        // Wrap from ch3 to ch0 and back to ch3.
        in_valid = 4'b1001;
        tick;
        chk_out("wrap_a", 1'b1, 8'h08, 2'd3);
        tick;
        chk_out("wrap_b", 1'b1, 8'h01, 2'd0);
        tick;
        chk_out("wrap_c", 1'b1, 8'h08, 2'd3);

        // Reset while holding a word.
        rst      = 1'b1;
        in_valid = 4'b1111;
        chk_rdy("midrst", 4'b0000);
        tick;
        chk_out("midrst", 1'b0, 8'h00, 2'd0);
        rst = 1'b0;
        tick;
        chk_out("post_rst0", 1'b1, 8'h01, 2'd0);
        tick;
        chk_out("post_rst1", 1'b1, 8'h02, 2'd1);

        // Reset with ptr advanced must restart at ch0.
        rst = 1'b1;
        tick;
        rst = 1'b0;
        tick;
        chk_out("ptr_clear", 1'b1, 8'h01, 2'd0);

        // No requests: output empties, data/sel hold.
        in_valid = 4'b0000;
        chk_rdy("empty", 4'b0000);
        tick;
        chk_out("empty", 1'b0, 8'h01, 2'd0);

`ifdef RR_MUX_FORCE_SEL_EN
        in_valid  = 4'b1111;
        force_en  = 1'b1;
        force_sel = 2'd2;
        for (int k = 0; k < 3; k++) begin
            chk_rdy("force", 4'b0100);
            tick;
            chk_out("force", 1'b1, 8'h04, 2'd2);
        end
        force_en = 1'b0;
        tick;
        chk_out("force_resume", 1'b1, 8'h02, 2'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rr_mux_arb.md
RR_MUX_ARB -- requirements
Module: rr_mux_arb

Interface
REQ-001 Parameter WIDTH, default 8: data width per channel in bits (1..64).
REQ-002 Parameter N, default 4: number of input channels (2..16); SW = clog2(N).
REQ-003 clk  input  1: single clock; all state updates on rising edge.
REQ-004 rst  input  1: synchronous, active-high reset.
REQ-005 in_data  input  N*WIDTH: flattened channel data; channel i at bits [i*WIDTH +: WIDTH].
REQ-006 in_valid  input  N: channel i offers a word.
REQ-007 in_ready  output  N: channel i word accepted this cycle when in_valid[i] && in_ready[i].
REQ-008 out_data  output  WIDTH: registered selected word.
REQ-009 out_sel  output  SW: index of the channel that produced out_data.
REQ-010 out_valid  output  1: out_data/out_sel hold a word.
REQ-011 out_ready  input  1: downstream accepts the word when out_valid && out_ready.

Function
REQ-012 One output register slot; load_en = !out_valid || out_ready.
REQ-013 Grant: round-robin over in_valid, searching from index ptr upward with wrap N-1 -> 0; the first valid channel wins.
REQ-014 in_ready SHALL be one-hot with the granted channel when load_en and any in_valid; otherwise all zero. It is combinational from in_valid, ptr, out_valid and out_ready.
REQ-015 On a transfer from channel g: out_data <= channel g data, out_sel <= g, out_valid <= 1, ptr <= (g+1) mod N.
REQ-016 If load_en and no in_valid: out_valid <= 0; out_data, out_sel and ptr hold.
REQ-017 If !load_en (out_valid && !out_ready): out_data, out_sel, out_valid and ptr hold stable; no channel is granted.
REQ-018 Latency: input accept to out_valid is 1 cycle. Full throughput: one word per cycle while out_ready = 1.
REQ-019 A simultaneous output drain and input accept in the same cycle SHALL both complete, with no bubble.
REQ-020 No channel waits more than N-1 grants while its in_valid stays asserted.
REQ-021 ptr wrap: when g = N-1, ptr becomes 0.

Reset
REQ-022 While rst = 1 at a clock edge: out_valid = 0, out_data = 0, out_sel = 0, ptr = 0.
REQ-023 in_ready SHALL be all zero during the reset cycle.
REQ-024 Reset mid-transfer discards the held word; the cycle after rst deasserts behaves as empty with ptr = 0.

Configuration
REQ-025 Macro RR_MUX_FORCE_SEL_EN, when defined, adds input force_en (1) and input force_sel (SW).
REQ-026 With the macro, force_en = 1 grants only channel force_sel, and only if that channel's in_valid is set. ptr SHALL not update on forced transfers.
REQ-027 Without the macro, the ports are absent and arbitration is pure round-robin per REQ-013.

Verification (N=4, WIDTH=8, data ch0..3 = 8'h01, 8'h02, 8'h04, 8'h08)
REQ-028 Reset, then all in_valid = 4'b1111, out_ready = 1 for 8 cycles -> out_sel sequence 0,1,2,3,0,1,2,3; out_data 01,02,04,08,...; out_valid = 1 from cycle 2.
REQ-029 in_valid = 4'b0100 only, out_ready = 1 -> in_ready = 4'b0100 each cycle; out_data = 8'h04 and out_sel = 2 every cycle after the first.
REQ-030 Word held from ch1 (out_data = 8'h02), out_ready = 0 for 3 cycles with in_valid = 4'b1111 -> in_ready = 0 and out_data = 8'h02 stable. Then out_ready = 1 -> next out_sel = 2.
REQ-031 in_valid = 4'b1001 after grant to ch3 -> next grant is ch0 (wrap), then ch3.
REQ-032 rst asserted while out_valid = 1 (out_data = 8'h08) -> next cycle out_valid = 0, out_data = 0, out_sel = 0. The first grant after reset with in_valid = 4'b1111 is ch0.
REQ-033 With RR_MUX_FORCE_SEL_EN: force_en = 1, force_sel = 2, in_valid = 4'b1111 for 3 cycles -> out_data = 8'h04 each cycle. After force_en = 0, arbitration resumes from the unchanged ptr.
